// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store
// requests onto an 8-bit RAM port, moving one byte per cycle.
module mem_ctrl #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        clear_flag,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    input  logic [1:0]  lsb_size,
    input  logic        lsb_signed,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata
);
    // state | meaning
    // IDLE  | waiting for a request; arbitration happens here
    // READ  | fetch or load in flight, one byte captured per cycle
    // WRITE | store in flight, one byte driven per cycle
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d, n_q, n_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, mem_a_q, mem_a_d;
    logic [31:0] if_data_q, if_data_d, lsb_rdata_q, lsb_rdata_d;
    logic [23:0] buf_q, buf_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d, if_done_q, if_done_d, lsb_done_q, lsb_done_d;
    logic        is_if_q, is_if_d, signed_q, signed_d, last_lsb_q, last_lsb_d;

    logic        lsb_ok, accept, pick_lsb, last_byte;
    logic [2:0]  lsb_n;
    logic [31:0] next_a, rd_word, rd_ext;

    assign lsb_ok    = lsb_req && !(lsb_wr && lsb_addr[17:16] == IO_HI && io_buffer_full);
    assign accept    = !clear_flag && !if_done_q && !lsb_done_q && (lsb_ok || if_req);
    // LSB wins a tie unless it also took the previous grant.
    assign pick_lsb  = lsb_ok && (!if_req || !last_lsb_q);
    assign lsb_n     = (lsb_size == 2'd0) ? 3'd1 : (lsb_size == 2'd1) ? 3'd2 : 3'd4;
    assign last_byte = (cnt_q == n_q);
    assign next_a    = addr_q + {29'd0, cnt_q};

    always_comb begin
        case (n_q)
            3'd1:    rd_word = {24'd0, mem_din};
            3'd2:    rd_word = {16'd0, mem_din, buf_q[7:0]};
            default: rd_word = {mem_din, buf_q};
        endcase
        rd_ext = rd_word;
        if (signed_q && n_q == 3'd1)      rd_ext = {{24{rd_word[7]}}, rd_word[7:0]};
        else if (signed_q && n_q == 3'd2) rd_ext = {{16{rd_word[15]}}, rd_word[15:0]};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)   state_q <= IDLE;
        else if (rdy_in) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (pick_lsb && lsb_wr) ? WRITE : READ;
            READ:    if (clear_flag || last_byte) state_d = IDLE;
            WRITE:   if (last_byte) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        n_d         = n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        buf_d       = buf_q;
        if_data_d   = if_data_q;
        lsb_rdata_d = lsb_rdata_q;
        is_if_d     = is_if_q;
        signed_d    = signed_q;
        last_lsb_d  = last_lsb_q;
        if_done_d   = 1'b0;
        lsb_done_d  = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                addr_d     = pick_lsb ? lsb_addr : if_addr;
                mem_a_d    = pick_lsb ? lsb_addr : if_addr;
                n_d        = pick_lsb ? lsb_n : 3'd4;
                signed_d   = pick_lsb && lsb_signed;
                is_if_d    = !pick_lsb;
                last_lsb_d = pick_lsb;
                wdata_d    = lsb_wdata;
                cnt_d      = 3'd1;
                mem_wr_d   = pick_lsb && lsb_wr;
                if (pick_lsb && lsb_wr) mem_dout_d = lsb_wdata[7:0];
            end
            READ: begin
                if (clear_flag) begin
                    mem_a_d  = 32'd0;
                    mem_wr_d = 1'b0;
                    cnt_d    = 3'd0;
                end else if (last_byte) begin
                    mem_a_d = 32'd0;
                    cnt_d   = 3'd0;
                    if (is_if_q) begin
                        if_done_d = 1'b1;
                        if_data_d = rd_word;
                    end else begin
                        lsb_done_d  = 1'b1;
                        lsb_rdata_d = rd_ext;
                    end
                end else begin
                    case (cnt_q)
                        3'd1:    buf_d[7:0]   = mem_din;
                        3'd2:    buf_d[15:8]  = mem_din;
                        default: buf_d[23:16] = mem_din;
                    endcase
                    mem_a_d = next_a;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            WRITE: begin
                if (last_byte) begin
                    mem_wr_d    = 1'b0;
                    mem_a_d     = 32'd0;
                    cnt_d       = 3'd0;
                    lsb_done_d  = 1'b1;
                    lsb_rdata_d = 32'd0;
                end else begin
                    mem_a_d = next_a;
                    cnt_d   = cnt_q + 3'd1;
                    case (cnt_q)
                        3'd1:    mem_dout_d = wdata_q[15:8];
                        3'd2:    mem_dout_d = wdata_q[23:16];
                        default: mem_dout_d = wdata_q[31:24];
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q       <= 3'd0;
            n_q         <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            mem_a_q     <= 32'd0;
            mem_dout_q  <= 8'd0;
            mem_wr_q    <= 1'b0;
            buf_q       <= 24'd0;
            if_data_q   <= 32'd0;
            lsb_rdata_q <= 32'd0;
            if_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            is_if_q     <= 1'b0;
            signed_q    <= 1'b0;
            last_lsb_q  <= 1'b0;
        end else if (rdy_in) begin
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            buf_q       <= buf_d;
            if_data_q   <= if_data_d;
            lsb_rdata_q <= lsb_rdata_d;
            if_done_q   <= if_done_d;
            lsb_done_q  <= lsb_done_d;
            is_if_q     <= is_if_d;
            signed_q    <= signed_d;
            last_lsb_q  <= last_lsb_d;
        end
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q & rdy_in;
    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign lsb_done  = lsb_done_q;
    assign lsb_rdata = lsb_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-addressed RAM model answers the port,
// and expected words/writes are queued at issue time and popped by monitors.
module tb_mem_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, clear_flag, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        lsb_req, lsb_wr, lsb_signed, lsb_done;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
    logic [1:0]  lsb_size;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_size(lsb_size), .lsb_signed(lsb_signed), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0, errors = 0;
    logic [7:0]  ram [logic [31:0]];
    logic [7:0]  mdl [logic [31:0]];
    logic [31:0] if_q[$], lsb_q[$];
    logic [39:0] wexp_q[$];
    int          done_log[$];
    int          if_cnt = 0, lsb_cnt = 0;
    logic        prev_if = 1'b0, prev_lsb = 1'b0;
    bit          if_fin, lsb_fin;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction
    function automatic logic [7:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        vectors++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        mdl[a] = b;
    endtask

    task automatic issue_if(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mdl_rd(a + 32'(k));
        if_q.push_back(w);
        if_addr = a;
        if_req  = 1'b1;
    endtask

    task automatic issue_lsb(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] sz, input bit sg);
        int n;
        logic [31:0] v, ak;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v = 32'd0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            if (wr) begin
                mdl[ak] = wd[8*k +: 8];
                wexp_q.push_back({ak, wd[8*k +: 8]});
            end else begin
                v[8*k +: 8] = mdl_rd(ak);
            end
        end
        if (!wr && sg && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!wr && sg && n == 2) v = {{16{v[15]}}, v[15:0]};
        lsb_q.push_back(wr ? 32'd0 : v);
        lsb_wr = wr; lsb_addr = a; lsb_wdata = wd; lsb_size = sz; lsb_signed = sg;
        lsb_req = 1'b1;
    endtask

    task automatic wait_if();
        int start = if_cnt;
        int t = 0;
        while (if_cnt == start && t < 500) begin @(negedge clk_in); t++; end
        if (if_cnt == start) fail_event("if_timeout", "no if_done within 500 cycles");
        if_req = 1'b0;
    endtask

    task automatic wait_lsb();
        int start = lsb_cnt;
        int t = 0;
        while (lsb_cnt == start && t < 500) begin @(negedge clk_in); t++; end
        if (lsb_cnt == start) fail_event("lsb_timeout", "no lsb_done within 500 cycles");
        lsb_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // RAM side: commit writes seen this cycle, then present the byte for mem_a.
    always @(negedge clk_in) begin
        logic [39:0] w;
        #2;
        if (mem_wr) begin
            if (wexp_q.size() == 0) begin
                fail_event("unexpected_write", $sformatf("addr 0x%08h data 0x%02h", mem_a, mem_dout));
            end else begin
                w = wexp_q.pop_front();
                check("wr_addr", mem_a, w[39:8]);
                check("wr_data", {24'd0, mem_dout}, {24'd0, w[7:0]});
            end
            ram[mem_a] = mem_dout;
        end
        mem_din = ram_rd(mem_a);
    end

    always @(posedge clk_in) begin
        #1;
        if (if_done && lsb_done) fail_event("done_overlap", "if_done and lsb_done both high");
        if (if_done && !prev_if) begin
            if_cnt++;
            done_log.push_back(0);
            if (if_q.size() == 0) fail_event("if_done_spurious", "no fetch outstanding");
            else check("if_data", if_data, if_q.pop_front());
        end
        if (lsb_done && !prev_lsb) begin
            lsb_cnt++;
            done_log.push_back(1);
            if (lsb_q.size() == 0) fail_event("lsb_done_spurious", "no access outstanding");
            else check("lsb_rdata", lsb_rdata, lsb_q.pop_front());
        end
        prev_if  = if_done;
        prev_lsb = lsb_done;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        rst_n_in = 1'b0; rdy_in = 1'b1; clear_flag = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'd0;
        lsb_wdata = 32'd0; lsb_size = 2'd0; lsb_signed = 1'b0; mem_din = 8'd0;
        idle(3);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_if_done", 32'(if_done), 32'd0);
        check("rst_lsb_done", 32'(lsb_done), 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_lsb_rdata", lsb_rdata, 32'd0);
        rst_n_in = 1'b1;
        idle(2);

        // Simultaneous requests after reset: LSB first, then alternate.
        issue_lsb(1'b0, 32'h0002_0000, 32'd0, 2'd2, 1'b0);
        issue_if(32'h0000_0200);
        fork wait_lsb(); wait_if(); join
        idle(1);
        issue_lsb(1'b0, 32'h0002_0004, 32'd0, 2'd1, 1'b1);
        issue_if(32'h0000_0204);
        fork wait_lsb(); wait_if(); join
        check("arb_order0", 32'(done_log[0]), 32'd1);
        check("arb_order1", 32'(done_log[1]), 32'd0);
        check("arb_order2", 32'(done_log[2]), 32'd1);
        check("arb_order3", 32'(done_log[3]), 32'd0);
        idle(2);

        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        issue_if(32'h100);
        @(posedge clk_in); #1;
        check("fetch_a0", mem_a, 32'h100);
        check("fetch_wr", 32'(mem_wr), 32'd0);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk_in); #1;
            check("fetch_a", mem_a, 32'h100 + 32'(k));
            check("fetch_early_done", 32'(if_done), 32'd0);
        end
        @(posedge clk_in); #1;
        check("fetch_done", 32'(if_done), 32'd1);
        check("fetch_word", if_data, 32'h0000_0513);
        check("fetch_a_idle", mem_a, 32'd0);
        @(negedge clk_in); if_req = 1'b0;
        idle(2);

        preload(32'h2003, 8'h80);
        issue_lsb(1'b0, 32'h2003, 32'd0, 2'd0, 1'b1);
        @(posedge clk_in); #1;
        check("lb_a", mem_a, 32'h2003);
        check("lb_early_done", 32'(lsb_done), 32'd0);
        @(posedge clk_in); #1;
        check("lb_done", 32'(lsb_done), 32'd1);
        check("lb_signed", lsb_rdata, 32'hFFFF_FF80);
        @(negedge clk_in); lsb_req = 1'b0;
        idle(2);
        issue_lsb(1'b0, 32'h2003, 32'd0, 2'd0, 1'b0);
        wait_lsb();
        check("lbu_value", lsb_rdata, 32'h0000_0080);
        idle(2);

        issue_lsb(1'b1, 32'h40, 32'h1122_3344, 2'd2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_in); #1;
            check("sw_wr", 32'(mem_wr), 32'd1);
            check("sw_a", mem_a, 32'h40 + 32'(k));
            check("sw_dout", {24'd0, mem_dout}, 32'(8'h44 - 8'(k * 8'h11)));
        end
        @(posedge clk_in); #1;
        check("sw_wr_end", 32'(mem_wr), 32'd0);
        check("sw_done", 32'(lsb_done), 32'd1);
        @(negedge clk_in); lsb_req = 1'b0;
        idle(2);

        // Flush during the second byte of a word load.
        issue_lsb(1'b0, 32'h0002_0010, 32'd0, 2'd2, 1'b0);
        @(posedge clk_in); @(posedge clk_in);
        @(negedge clk_in); clear_flag = 1'b1; lsb_req = 1'b0; void'(lsb_q.pop_back());
        @(posedge clk_in); #1;
        check("flush_a", mem_a, 32'd0);
        check("flush_done", 32'(lsb_done), 32'd0);
        @(negedge clk_in); clear_flag = 1'b0;
        saved = lsb_cnt;
        idle(6);
        check("flush_no_done", 32'(lsb_cnt), 32'(saved));

        // Flush during a store does not abort it.
        issue_lsb(1'b1, 32'h0002_0020, 32'hA1B2_C3D4, 2'd2, 1'b0);
        @(posedge clk_in); @(posedge clk_in);
        @(negedge clk_in); clear_flag = 1'b1;
        @(negedge clk_in); clear_flag = 1'b0;
        wait_lsb();
        check("flush_store_writes_left", 32'(wexp_q.size()), 32'd0);
        idle(2);

        // Flush in IDLE blocks acceptance on that edge.
        clear_flag = 1'b1;
        issue_if(32'h10);
        @(posedge clk_in); #1;
        check("idle_flush_blocks", mem_a, 32'd0);
        @(negedge clk_in); clear_flag = 1'b0;
        @(posedge clk_in); #1;
        check("idle_flush_release", mem_a, 32'h10);
        wait_if();
        idle(2);

        // Ready low holds the write and masks mem_wr.
        issue_lsb(1'b1, 32'h0002_0030, 32'h0000_005A, 2'd0, 1'b0);
        @(posedge clk_in); #1;
        check("rdy_wr_before", 32'(mem_wr), 32'd1);
        @(negedge clk_in); rdy_in = 1'b0; #1;
        check("rdy_wr_masked", 32'(mem_wr), 32'd0);
        @(posedge clk_in); #1;
        check("rdy_hold_a", mem_a, 32'h0002_0030);
        check("rdy_hold_done", 32'(lsb_done), 32'd0);
        @(negedge clk_in); rdy_in = 1'b1;
        wait_lsb();
        idle(2);

        // I/O store held off while the buffer is full.
        io_buffer_full = 1'b1;
        issue_lsb(1'b1, 32'h0003_0000, 32'h0000_0077, 2'd0, 1'b0);
        repeat (5) begin
            @(posedge clk_in); #1;
            check("io_full_no_wr", 32'(mem_wr), 32'd0);
            check("io_full_no_accept", mem_a, 32'd0);
        end
        @(negedge clk_in); io_buffer_full = 1'b0;
        @(posedge clk_in); #1;
        check("io_release_wr", 32'(mem_wr), 32'd1);
        check("io_release_a", mem_a, 32'h0003_0000);
        wait_lsb();
        idle(2);

        // Asynchronous reset in the middle of a fetch.
        issue_if(32'h300);
        @(posedge clk_in); @(posedge clk_in);
        #3 rst_n_in = 1'b0;
        #1;
        check("arst_mem_a", mem_a, 32'd0);
        check("arst_mem_wr", 32'(mem_wr), 32'd0);
        check("arst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("arst_if_done", 32'(if_done), 32'd0);
        check("arst_lsb_done", 32'(lsb_done), 32'd0);
        check("arst_if_data", if_data, 32'd0);
        check("arst_lsb_rdata", lsb_rdata, 32'd0);
        void'(if_q.pop_back());
        if_req = 1'b0;
        @(negedge clk_in); rst_n_in = 1'b1;
        idle(2);

        if_fin = 1'b0; lsb_fin = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    bit wr, sg;
                    logic [1:0]  sz;
                    logic [31:0] a, wd;
                    int r;
                    idle($urandom_range(0, 3));
                    wr = 1'($urandom % 2); sg = 1'($urandom % 2);
                    sz = 2'($urandom_range(0, 2)); wd = $urandom;
                    r  = wr ? 0 : int'($urandom % 3);
                    if (r == 0)      a = {14'd0, ($urandom % 2) ? 2'b11 : 2'b10, 16'($urandom)};
                    else if (r == 1) a = 32'($urandom_range(0, 16'hFFFF));
                    else             a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                    issue_lsb(wr, a, wd, sz, sg);
                    wait_lsb();
                end
                lsb_fin = 1'b1;
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [31:0] a;
                    idle($urandom_range(0, 3));
                    if ($urandom % 8 == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                    else                   a = 32'($urandom_range(0, 16'hFFFF));
                    issue_if(a);
                    wait_if();
                end
                if_fin = 1'b1;
            end
            begin
                while (!(if_fin && lsb_fin)) begin
                    @(negedge clk_in);
                    rdy_in         = ($urandom % 5) != 0;
                    io_buffer_full = ($urandom % 4) == 0;
                end
            end
        join
        rdy_in = 1'b1; io_buffer_full = 1'b0;
        idle(10);
        check("if_q_drained", 32'(if_q.size()), 32'd0);
        check("lsb_q_drained", 32'(lsb_q.size()), 32'd0);
        check("wr_q_drained", 32'(wexp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter IO_HI, default 2'b11: value of address bits [17:16] that marks an I/O-mapped address.
REQ-002 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous and active-low.
REQ-004 rdy_in  input  1  ready; low pauses the block.
REQ-005 clear_flag  input  1  mispredict flush.
REQ-006 mem_din  input  8  RAM read byte, valid one cycle after its address is driven.
REQ-007 mem_dout  output  8  RAM write byte.
REQ-008 mem_a  output  32  RAM byte address.
REQ-009 mem_wr  output  1  RAM write enable, 1 = write.
REQ-010 io_buffer_full  input  1  I/O write buffer full.
REQ-011 if_req  input  1  instruction-fetch request; held until if_done.
REQ-012 if_addr  input  32  fetch word address.
REQ-013 if_done  output  1  one-cycle pulse: if_data valid.
REQ-014 if_data  output  32  fetched word.
REQ-015 lsb_req  input  1  load/store request; held until lsb_done.
REQ-016 lsb_wr  input  1  1 = store, 0 = load.
REQ-017 lsb_addr  input  32  byte address.
REQ-018 lsb_wdata  input  32  store data; low bytes used.
REQ-019 lsb_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-020 lsb_signed  input  1  1 = sign-extend the load result.
REQ-021 lsb_done  output  1  one-cycle pulse: access complete.
REQ-022 lsb_rdata  output  32  load result; 0 for stores.

Function
REQ-023 FSM states: IDLE, READ, WRITE. Byte counter cnt is 3 bits. Byte count n = 4 for a fetch; 1, 2 or 4 for the LSB.
REQ-024 Accept in IDLE only when neither if_done nor lsb_done is high.
REQ-025 Store with addr[17:16]==IO_HI is not accepted while io_buffer_full=1.
REQ-026 Arbitration when both requests are pending: round-robin on the last grant; after reset the LSB wins first.
REQ-027 Accept edge E0 (read): mem_a<=addr, mem_wr<=0, cnt<=1, state<=READ.
REQ-028 READ, edge Ek (k=1..n): capture mem_din as byte k-1, little-endian; if k<n then mem_a<=addr+k.
REQ-029 READ, edge En: the done pulse and data register are set, mem_a<=0, state<=IDLE. Done is therefore visible n cycles after E0.
REQ-030 Load result: zero-extended, or sign-extended from bit 7 (byte) or bit 15 (half) when lsb_signed=1.
REQ-031 Accept edge E0 (write): mem_a<=addr, mem_dout<=wdata[7:0], mem_wr<=1, state<=WRITE.
REQ-032 WRITE, edge Ek (k<n): mem_a<=addr+k, mem_dout<=wdata[8k+7:8k].
REQ-033 WRITE, edge En: mem_wr<=0, lsb_done<=1, state<=IDLE.
REQ-034 Address arithmetic is 32-bit and wraps modulo 2^32; there is no alignment check.
REQ-035 if_done and lsb_done are high for exactly one cycle and never simultaneously.
REQ-036 clear_flag aborts an in-flight fetch or load: next edge goes to IDLE, mem_wr=0, no done pulse.
REQ-037 clear_flag does not abort an in-flight store; it completes and pulses lsb_done.
REQ-038 clear_flag in IDLE blocks acceptance on that edge.
REQ-039 rdy_in low holds every register (state, cnt, outputs); mem_wr is driven as mem_wr_reg AND rdy_in.

Reset
REQ-040 rst_n_in low asynchronously forces: state=IDLE, cnt=0, mem_a=0, mem_dout=0, mem_wr=0, if_done=0, lsb_done=0, if_data=0, lsb_rdata=0, last grant = IF. Any access in progress is dropped.

Verification
REQ-041 Fetch: if_req, addr 0x100, RAM bytes 0x13,0x05,0x00,0x00 -> mem_a 0x100..0x103, if_done 4 cycles after accept, if_data=0x00000513.
REQ-042 Signed byte load of 0x80 at 0x2003 -> lsb_done after 1 cycle, lsb_rdata=0xFFFFFF80; same access unsigned -> 0x00000080.
REQ-043 SW 0x11223344 to 0x40 -> mem_wr high 4 cycles, bytes 44,33,22,11 at 0x40..0x43, then lsb_done.
REQ-044 if_req and lsb_req raised on the same cycle after reset -> LSB served first, then fetch; neither request starves.
REQ-045 clear_flag during the 2nd byte of a word load -> IDLE, no lsb_done. clear_flag during a store -> store completes.
REQ-046 SB to 0x30000 with io_buffer_full=1 for 5 cycles -> no mem_wr during those cycles; accept after release. rst_n_in pulsed mid-read -> all outputs 0 immediately.
